msk_seed_ser: RTL and testbench

MSK_SEED_SER -- requirements
Module: msk_seed_ser

---
 rtl/msk_seed_ser.sv | 126 ++++++++++++
 tb/tb_msk_seed_ser.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_seed_ser.sv
// Seed serializer for the masked NLFSR: takes one 56-bit seed word and streams it LSB-first.
// Optional inter-bit idle gap (i_gap port, GAP state) is enabled by defining MSK_SEED_SER_GAP_EN.
module msk_seed_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [55:0] i_wdata,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_abort,
`ifdef MSK_SEED_SER_GAP_EN
    input  logic [3:0]  i_gap,
`endif
    output logic        o_ser_in_valid,
    output logic        o_ser_in,
    output logic        o_halt,
    output logic        o_done,
    output logic [5:0]  o_bit_cnt
);

`ifdef MSK_SEED_SER_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [55:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        strobe;
`ifdef MSK_SEED_SER_GAP_EN
    logic [3:0]  gap_q, gap_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
`endif

    // NOTE: the shift register is a plain flop vector, so it takes the async reset with the
    // rest of the state; a word interrupted by reset must not leak into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
`ifdef MSK_SEED_SER_GAP_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
`ifdef MSK_SEED_SER_GAP_EN
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path through the case leaves a latch behind.
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        strobe    = 1'b0;
`ifdef MSK_SEED_SER_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    sr_d    = i_wdata;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef MSK_SEED_SER_GAP_EN
                    gap_d   = i_gap;
`endif
                end
            end
            ST_SHIFT: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end else begin
                    strobe = 1'b1;
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + 6'd1;
                    // No gap after the final bit: go straight to DONE.
                    if (cnt_q == 6'd55) begin
                        state_d = ST_DONE;
`ifdef MSK_SEED_SER_GAP_EN
                    end else if (gap_q != 4'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
`ifdef MSK_SEED_SER_GAP_EN
            ST_GAP: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end else if (gap_cnt_q == 4'd1) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ready        = (state_q == ST_IDLE);
    assign o_halt         = (state_q != ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_ser_in_valid = strobe;
    assign o_ser_in       = strobe & sr_q[0];
    assign o_bit_cnt      = cnt_q;

endmodule

// File: tb/tb_msk_seed_ser.sv
// Self-checking bench for msk_seed_ser: schedule-based reference model checked every cycle,
// plus directed scenarios with literal latency/readback expectations (gap cases need MSK_SEED_SER_GAP_EN).
`timescale 1ns/1ps
module tb_msk_seed_ser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [55:0] i_wdata = '0;
    logic        i_valid = 1'b0;
    logic        i_abort = 1'b0;
    logic [3:0]  i_gap = '0;
    logic        o_ready, o_ser_in_valid, o_ser_in, o_halt, o_done;
    logic [5:0]  o_bit_cnt;

    always #5 clk = ~clk;

    msk_seed_ser dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wdata        (i_wdata),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_abort        (i_abort),
`ifdef MSK_SEED_SER_GAP_EN
        .i_gap          (i_gap),
`endif
        .o_ser_in_valid (o_ser_in_valid),
        .o_ser_in       (o_ser_in),
        .o_halt         (o_halt),
        .o_done         (o_done),
        .o_bit_cnt      (o_bit_cnt)
    );

`ifdef MSK_SEED_SER_GAP_EN
    localparam int LAT_GAP3 = 222;
    localparam int LAT_GAP1 = 112;
`else
    localparam int LAT_GAP3 = 57;
    localparam int LAT_GAP1 = 57;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_gap(input logic [3:0] g);
`ifdef MSK_SEED_SER_GAP_EN
        return int'(g);
`else
        return 0 * int'(g);
`endif
    endfunction

    // Reference model: a word accepted at an edge occupies cycles n = 1..L after it, L = 57 + 55*gap.
    // Strobes fall on n = 1 + k*(gap+1) carrying bit k; n = L is the done cycle.
    logic        m_active;
    int          m_n;
    int          m_gap;
    logic [55:0] m_word;
    logic [5:0]  m_idle_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active   <= 1'b0;
            m_n        <= 0;
            m_gap      <= 0;
            m_word     <= '0;
            m_idle_cnt <= '0;
        end else if (m_active) begin
            if (m_n == 57 + 55 * m_gap) begin
                m_active   <= 1'b0;
                m_idle_cnt <= 6'd56;
            end else if (i_abort) begin
                m_active   <= 1'b0;
                m_idle_cnt <= 6'd0;
            end else begin
                m_n <= m_n + 1;
            end
        end else if (i_valid) begin
            m_active <= 1'b1;
            m_n      <= 1;
            m_word   <= i_wdata;
            m_gap    <= eff_gap(i_gap);
        end
    end

    typedef struct packed {
        logic       ready;
        logic       halt;
        logic       valid;
        logic       ser;
        logic       done;
        logic [5:0] cnt;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        int   k;
        bit   strobe;
        e = '{ready: 1'b1, halt: 1'b0, valid: 1'b0, ser: 1'b0, done: 1'b0, cnt: m_idle_cnt};
        if (m_active) begin
            e.ready = 1'b0;
            e.halt  = 1'b1;
            if (m_n == 57 + 55 * m_gap) begin
                e.done = 1'b1;
                e.cnt  = 6'd56;
            end else begin
                strobe  = ((m_n - 1) % (m_gap + 1)) == 0;
                k       = (m_n - 1) / (m_gap + 1);
                e.valid = strobe && !i_abort;
                e.ser   = e.valid ? m_word[k] : 1'b0;
                e.cnt   = 6'(strobe ? k : k + 1);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        check("cmp_ready", 64'(o_ready),        64'(model_out().ready));
        check("cmp_halt",  64'(o_halt),         64'(model_out().halt));
        check("cmp_valid", 64'(o_ser_in_valid), 64'(model_out().valid));
        check("cmp_ser",   64'(o_ser_in),       64'(model_out().ser));
        check("cmp_done",  64'(o_done),         64'(model_out().done));
        check("cmp_cnt",   64'(o_bit_cnt),      64'(model_out().cnt));
    end

    // Observers: cycle index, transfer/done timestamps and a two-share MSB-in loopback register.
    int          cyc = 0;
    int          t_xfer = 0, t_done = 0, halt_cnt = 0, strobe_cnt = 0, done_cnt = 0;
    logic        first_bit = 1'b0;
    logic [55:0] share_a = '0, share_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && o_ready && i_valid) begin
            t_xfer     <= cyc;
            halt_cnt   <= 0;
            strobe_cnt <= 0;
            share_a    <= '0;
            share_b    <= '0;
        end else begin
            if (o_halt) halt_cnt <= halt_cnt + 1;
            if (o_ser_in_valid) begin
                if (strobe_cnt == 0) first_bit <= o_ser_in;
                strobe_cnt <= strobe_cnt + 1;
                share_a    <= {o_ser_in, share_a[55:1]};
                share_b    <= {o_ser_in, share_b[55:1]};
            end
            if (o_done) begin
                t_done   <= cyc;
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [55:0] w, input logic [3:0] g);
        i_wdata = w;
        i_gap   = g;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_wdata = ~w;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (o_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(found), 64'd1);
    endtask

    task automatic wait_cnt(input logic [5:0] target, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (o_bit_cnt === target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_cnt_reached"}, 64'(found), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 64'(o_ready),        64'd1);
        check({name, "_halt"},  64'(o_halt),         64'd0);
        check({name, "_valid"}, 64'(o_ser_in_valid), 64'd0);
        check({name, "_ser"},   64'(o_ser_in),       64'd0);
        check({name, "_done"},  64'(o_done),         64'd0);
        check({name, "_cnt"},   64'(o_bit_cnt),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int done_before;
    int t_done_a;

    initial begin
        // Reset state, then a transfer on the very first edge after release (word 1, gap 0).
        rst_n   = 1'b0;
        i_wdata = 56'h00_0000_0000_0001;
        i_gap   = 4'd0;
        i_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        i_valid = 1'b0;
        i_wdata = '1;
        wait_done(100, "w1");
        check("w1_latency",   64'(t_done - t_xfer), 64'd57);
        check("w1_halt_cyc",  64'(halt_cnt),        64'd57);
        check("w1_strobes",   64'(strobe_cnt),      64'd56);
        check("w1_first_bit", 64'(first_bit),       64'd1);
        check("w1_share_a",   64'(share_a),         64'h00_0000_0000_0001);
        check("w1_share_b",   64'(share_b),         64'h00_0000_0000_0001);
        tick();

        // Alternating pattern with gap 3 (gap ignored in the default build).
        send(56'hA5_5A5A_5A5A_5A5A, 4'd3);
        wait_done(400, "w2");
        check("w2_latency",  64'(t_done - t_xfer), 64'(LAT_GAP3));
        check("w2_halt_cyc", 64'(halt_cnt),        64'(LAT_GAP3));
        check("w2_strobes",  64'(strobe_cnt),      64'd56);
        check("w2_share_a",  64'(share_a),         64'hA5_5A5A_5A5A_5A5A);
        check("w2_share_b",  64'(share_b),         64'hA5_5A5A_5A5A_5A5A);
        tick();

        // Abort at bit count 20, then a new word offered in the very next cycle.
        send(56'hDE_ADBE_EFCA_FE12, 4'd0);
        wait_cnt(6'd20, "abort");
        done_before = done_cnt;
        i_abort = 1'b1;
        #1;
        check("abort_valid", 64'(o_ser_in_valid), 64'd0);
        check("abort_ser",   64'(o_ser_in),       64'd0);
        tick();
        i_abort = 1'b0;
        check("abort_ready", 64'(o_ready),   64'd1);
        check("abort_cnt",   64'(o_bit_cnt), 64'd0);
        check("abort_halt",  64'(o_halt),    64'd0);
        send(56'h12_3456_789A_BCDE, 4'd0);
        wait_done(100, "w3");
        check("w3_latency",  64'(t_done - t_xfer),        64'd57);
        check("w3_one_done", 64'(done_cnt - done_before), 64'd1);
        check("w3_share_a",  64'(share_a),                64'h12_3456_789A_BCDE);
        check("w3_share_b",  64'(share_b),                64'h12_3456_789A_BCDE);
        tick();

`ifdef MSK_SEED_SER_GAP_EN
        // Abort while idling in a gap.
        send(56'h55_AA55_AA55_AA55, 4'd2);
        wait_cnt(6'd5, "gabort");
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("gabort_ready", 64'(o_ready),   64'd1);
        check("gabort_cnt",   64'(o_bit_cnt), 64'd0);
        tick();
`endif

        // Reset in the middle of a word: asynchronous clear, no done afterwards.
        send(56'h0F_1E2D_3C4B_5A69, 4'd0);
        wait_cnt(6'd40, "rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        done_before = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (80) tick();
        check("midrst_no_done", 64'(done_cnt - done_before), 64'd0);

        // i_valid held through DONE: second word taken only in the following IDLE cycle.
        i_wdata = 56'h3C_C3F0_0F69_96A5;
        i_gap   = 4'd1;
        i_valid = 1'b1;
        tick();
        i_wdata = 56'h81_4218_2442_1881;
        wait_done(300, "w5a");
        t_done_a = t_done;
        check("w5a_latency", 64'(t_done - t_xfer), 64'(LAT_GAP1));
        check("w5a_share_a", 64'(share_a),         64'h3C_C3F0_0F69_96A5);
        check("w5a_share_b", 64'(share_b),         64'h3C_C3F0_0F69_96A5);
        tick();
        tick();
        i_valid = 1'b0;
        i_wdata = '0;
        check("w5b_xfer_after_done", 64'(t_xfer - t_done_a), 64'd1);
        wait_done(300, "w5b");
        check("w5b_share_a", 64'(share_a), 64'h81_4218_2442_1881);
        check("w5b_share_b", 64'(share_b), 64'h81_4218_2442_1881);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
